// File: rtl/reg_bank_display.sv
// Register-bank viewer: live/shadow banks drawn as a bit grid, with the last written row highlighted.
// Optional macro REG_BANK_DISPLAY_GRID_EN draws blue cell borders on zero bits.
module reg_bank_display #(
    parameter int REG_COUNT   = 8,
    parameter int REG_WIDTH   = 16,
    parameter int CELL_SHIFT  = 2,
    parameter int ORIGIN_X    = 256,
    parameter int ORIGIN_Y    = 0,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wr_en,
    input  logic [$clog2(REG_COUNT)-1:0] wr_addr,
    input  logic [REG_WIDTH-1:0]         wr_data,
    input  logic                         frame_start,
    input  logic [9:0]                   hpos,
    input  logic [9:0]                   vpos,
    input  logic                         display_on,
    output logic                         vga_R,
    output logic                         vga_G,
    output logic                         vga_B
);
    localparam int AW       = $clog2(REG_COUNT);
    localparam int CW       = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
    localparam int REGION_W = REG_WIDTH << CELL_SHIFT;
    localparam int REGION_H = REG_COUNT << CELL_SHIFT;

    typedef enum logic {IDLE, HOLD} hlState_e;

    logic [REG_WIDTH-1:0] live_q   [REG_COUNT];
    logic [REG_WIDTH-1:0] shadow_q [REG_COUNT];

    hlState_e      state_q;
    logic [AW-1:0] hlRow_q;
    logic [AW-1:0] hlShadowRow_q;
    logic          hlShadowOn_q;
    logic [7:0]    holdCnt_q;

    logic          inRegion_d, inRegion_q;
    logic [AW-1:0] row_d, row_q;
    logic [CW-1:0] col_d, col_q;

    logic          wrValid;
    logic [9:0]    relX, relY;
    logic          cellBit;
    logic          hlHit;

    assign wrValid = wr_en && (32'(wr_addr) < 32'(REG_COUNT));

    // Shadow takes the whole live bank at frame_start, with the same-cycle write bypassed in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            if (wrValid) live_q[wr_addr] <= wr_data;
            if (frame_start) begin
                for (int i = 0; i < REG_COUNT; i++)
                    shadow_q[i] <= (wrValid && wr_addr == AW'(i)) ? wr_data : live_q[i];
            end
        end
    end

    // Highlight FSM; the rendered copy of its state is latched with the shadow bank.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            hlRow_q       <= '0;
            holdCnt_q     <= '0;
            hlShadowRow_q <= '0;
            hlShadowOn_q  <= 1'b0;
        end else begin
            if (frame_start) begin
                hlShadowOn_q  <= (state_q == HOLD);
                hlShadowRow_q <= hlRow_q;
            end
            case (state_q)
                IDLE: begin
                    if (wrValid) begin
                        state_q   <= HOLD;
                        hlRow_q   <= wr_addr;
                        holdCnt_q <= 8'(HOLD_FRAMES);
                    end
                end
                HOLD: begin
                    if (wrValid) begin
                        hlRow_q   <= wr_addr;
                        holdCnt_q <= 8'(HOLD_FRAMES);
                    end else if (frame_start) begin
                        if (holdCnt_q == 8'd1) begin
                            state_q   <= IDLE;
                            holdCnt_q <= '0;
                        end else begin
                            holdCnt_q <= holdCnt_q - 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Unsigned wrap puts positions left of / above the origin far outside the region.
    assign relX       = hpos - 10'(ORIGIN_X);
    assign relY       = vpos - 10'(ORIGIN_Y);
    assign inRegion_d = display_on && (32'(relX) < 32'(REGION_W)) && (32'(relY) < 32'(REGION_H));
    assign row_d      = AW'(relY >> CELL_SHIFT);
    assign col_d      = CW'(relX >> CELL_SHIFT);

`ifdef REG_BANK_DISPLAY_GRID_EN
    localparam logic [9:0] CELL_MASK = 10'((1 << CELL_SHIFT) - 1);
    logic gridEdge_d, gridEdge_q;
    assign gridEdge_d = ((relX & CELL_MASK) == 10'd0) || ((relY & CELL_MASK) == 10'd0);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inRegion_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
`ifdef REG_BANK_DISPLAY_GRID_EN
            gridEdge_q <= 1'b0;
`endif
        end else begin
            inRegion_q <= inRegion_d;
            row_q      <= row_d;
            col_q      <= col_d;
`ifdef REG_BANK_DISPLAY_GRID_EN
            gridEdge_q <= gridEdge_d;
`endif
        end
    end

    assign cellBit = shadow_q[row_q][CW'(REG_WIDTH - 1) - col_q];
    assign hlHit   = hlShadowOn_q && (row_q == hlShadowRow_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_R <= 1'b0;
            vga_G <= 1'b0;
            vga_B <= 1'b0;
        end else begin
            vga_R <= inRegion_q && cellBit && hlHit;
            vga_G <= inRegion_q && cellBit && !hlHit;
`ifdef REG_BANK_DISPLAY_GRID_EN
            vga_B <= inRegion_q && !cellBit && gridEdge_q;
`else
            vga_B <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_reg_bank_display.sv
// Directed bench for reg_bank_display: pixel scans scored against a small bank model, 2-clock latency.
module tb_reg_bank_display;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        frame_start = 1'b0;
    logic [9:0]  hpos = '0;
    logic [9:0]  vpos = '0;
    logic        display_on = 1'b0;
    logic        vga_R, vga_G, vga_B;

    int checks = 0;
    int errors = 0;

    logic [15:0] mLive   [8];
    logic [15:0] mShadow [8];
    int          expHl = -1;

    typedef struct {
        logic [2:0] rgb;
        bit         chk;
        int         h;
        int         v;
    } exp_t;
    exp_t sbQ[$];

    reg_bank_display #(.HOLD_FRAMES(HOLD)) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] expPix(int h, int v, bit on);
        int x, y, r, c;
        logic b;
        x = h - 256;
        y = v;
        if (!on || x < 0 || x >= 64 || y < 0 || y >= 32) return 3'b000;
        r = y / 4;
        c = x / 4;
        b = mShadow[r][15 - c];
        if (b) return (r == expHl) ? 3'b100 : 3'b010;
`ifdef REG_BANK_DISPLAY_GRID_EN
        if (x % 4 == 0 || y % 4 == 0) return 3'b001;
`endif
        return 3'b000;
    endfunction

    task automatic checkEq(string tag, logic [2:0] obs, logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Scores the entry driven two negedges ago, i.e. two rising edges of latency.
    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() >= 2) begin
            e = sbQ.pop_front();
            if (e.chk) checkEq($sformatf("pix h=%0d v=%0d", e.h, e.v), {vga_R, vga_G, vga_B}, e.rgb);
        end
    endtask

    task automatic applyStimulus(int h, int v, bit on, bit chk);
        exp_t e;
        @(negedge clk);
        checkOutput();
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = on;
        e.rgb = expPix(h, v, on);
        e.chk = chk;
        e.h   = h;
        e.v   = v;
        sbQ.push_back(e);
    endtask

    task automatic scanLine(int v, bit on);
        for (int h = 250; h < 326; h++) applyStimulus(h, v, on, 1'b1);
        applyStimulus(0, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0);
    endtask

    task automatic writeReg(int addr, logic [15:0] data, bit withFrame);
        @(negedge clk);
        wr_en       = 1'b1;
        wr_addr     = 3'(addr);
        wr_data     = data;
        frame_start = withFrame;
        @(negedge clk);
        wr_en       = 1'b0;
        frame_start = 1'b0;
        if (withFrame) for (int i = 0; i < 8; i++) mShadow[i] = mLive[i];
        mLive[addr] = data;
        if (withFrame) mShadow[addr] = data;
    endtask

    task automatic frameStart();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 8; i++) mShadow[i] = mLive[i];
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mLive[i]   = '0;
            mShadow[i] = '0;
        end

        repeat (3) @(negedge clk);
        checkEq("reset outputs", {vga_R, vga_G, vga_B}, 3'b000);
        resetn = 1'b1;

        // Nothing written yet: all cells black (or grid only).
        scanLine(13, 1'b1);

        writeReg(3, 16'h8001, 1'b0);
        scanLine(13, 1'b1);
        frameStart();
        expHl = 3;
        for (int v = 12; v < 16; v++) scanLine(v, 1'b1);

        // Mid-frame write is invisible until the next frame_start.
        writeReg(5, 16'hFFFF, 1'b0);
        scanLine(21, 1'b1);
        scanLine(13, 1'b1);
        frameStart();
        expHl = 5;
        scanLine(21, 1'b1);
        scanLine(12, 1'b1);

        // Row 5 stays red for HOLD frames in total, then turns green.
        frameStart();
        scanLine(20, 1'b1);
        frameStart();
        scanLine(22, 1'b1);
        frameStart();
        expHl = -1;
        scanLine(23, 1'b1);

        // A second write during the hold restarts the count.
        writeReg(1, 16'h00F0, 1'b0);
        frameStart();
        expHl = 1;
        scanLine(5, 1'b1);
        frameStart();
        writeReg(1, 16'h00F0, 1'b0);
        frameStart();
        frameStart();
        scanLine(6, 1'b1);
        frameStart();
        scanLine(7, 1'b1);
        frameStart();
        expHl = -1;
        scanLine(4, 1'b1);

        // Write coinciding with frame_start is bypassed into the shadow bank.
        writeReg(2, 16'h0000, 1'b0);
        writeReg(2, 16'h0004, 1'b1);
        expHl = 2;
        scanLine(8, 1'b1);
        scanLine(8, 1'b0);
        scanLine(31, 1'b1);
        scanLine(32, 1'b1);

        // Asynchronous reset over a lit cell.
        @(negedge clk);
        hpos       = 10'd309;
        vpos       = 10'd9;
        display_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkEq("lit before reset", {vga_R, vga_G, vga_B}, 3'b100);
        #2;
        resetn = 1'b0;
        #1;
        checkEq("async reset blank", {vga_R, vga_G, vga_B}, 3'b000);
        @(negedge clk);
        checkEq("held in reset", {vga_R, vga_G, vga_B}, 3'b000);
        display_on = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        sbQ.delete();
        for (int i = 0; i < 8; i++) begin
            mLive[i]   = '0;
            mShadow[i] = '0;
        end
        expHl = -1;

        frameStart();
        for (int v = 0; v < 32; v++) scanLine(v, 1'b1);

        writeReg(0, 16'hFFFF, 1'b0);
        scanLine(0, 1'b1);
        frameStart();
        expHl = 0;
        scanLine(2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_bank_display.md
REG_BANK_DISPLAY -- requirements
Module: reg_bank_display

Interface
REQ-001 Parameter REG_COUNT, default 8: number of displayed registers, from 2 to 16.
REQ-002 Parameter REG_WIDTH, default 16: bits per register, from 1 to 32.
REQ-003 Parameter CELL_SHIFT, default 2: each bit cell is 2^CELL_SHIFT pixels square.
REQ-004 Parameter ORIGIN_X, default 256: left pixel column of the display region.
REQ-005 Parameter ORIGIN_Y, default 0: top pixel line of the display region.
REQ-006 Parameter HOLD_FRAMES, default 30: frames for which a written register stays highlighted, from 1 to 255.
REQ-007 clk  in  1  pixel clock; the single clock of the block.
REQ-008 resetn  in  1  asynchronous active-low reset.
REQ-009 wr_en  in  1  register write strobe, one write per cycle.
REQ-010 wr_addr  in  clog2(REG_COUNT)  write register index.
REQ-011 wr_data  in  REG_WIDTH  write data.
REQ-012 frame_start  in  1  single-cycle pulse at the start of vertical blanking.
REQ-013 hpos, vpos  in  10 each  current beam position.
REQ-014 display_on  in  1  active video flag.
REQ-015 vga_R, vga_G, vga_B  out  1 each  registered colour outputs.

Function
REQ-016 Two banks SHALL be kept: a live bank, updated by writes, and a shadow bank, which is the only bank rendered.
REQ-017 A write with wr_en=1 SHALL update live[wr_addr] at the clock edge; a wr_addr >= REG_COUNT SHALL be ignored.
REQ-018 On frame_start, all of the live bank SHALL be copied to the shadow bank in that same cycle, so the picture never tears.
REQ-019 If wr_en and frame_start are both high in one cycle, the shadow SHALL capture the new wr_data for wr_addr (write bypass).
REQ-020 Region: x = hpos-ORIGIN_X in [0, REG_WIDTH<<CELL_SHIFT) and y = vpos-ORIGIN_Y in [0, REG_COUNT<<CELL_SHIFT), using unsigned compare; positions left of or above the origin are outside.
REQ-021 Row r = y>>CELL_SHIFT; column c = x>>CELL_SHIFT; the bit shown SHALL be shadow[r][REG_WIDTH-1-c], so the MSB is at the left.
REQ-022 Pixel colour: bit=1 on the highlighted row is red; bit=1 on any other row is green; bit=0, outside the region, or display_on=0 is black.
REQ-023 Latency SHALL be exactly 2 clocks from hpos/vpos/display_on to vga_R/G/B, on a two-stage pipeline: stage 1 is the address/compare, stage 2 is the bit fetch and colour.
REQ-024 Highlight FSM with states IDLE and HOLD.
REQ-025 In IDLE, a valid write SHALL go to HOLD, with hl_row=wr_addr and the counter=HOLD_FRAMES.
REQ-026 In HOLD, each frame_start SHALL decrement the counter; at counter 1, frame_start SHALL return the FSM to IDLE.
REQ-027 In HOLD, a new valid write SHALL reload hl_row and the counter, and this SHALL take priority over a simultaneous decrement.
REQ-028 A row is highlighted only while the FSM is in HOLD and r==hl_row, sampled from the shadow-aligned copy of hl_row that is latched at frame_start.

Reset
REQ-029 While resetn=0, the following SHALL be zero regardless of clk: both banks, the pipeline registers, vga_R/G/B, hl_row, and the counter; the FSM SHALL be in IDLE.
REQ-030 A reset asserted mid-frame SHALL blank the outputs on that same edge, and a write in progress SHALL be lost.
REQ-031 After the release of resetn, the display SHALL show all-black cells until the first frame_start following a write.

Configuration
REQ-032 Macro REG_BANK_DISPLAY_GRID_EN: when defined, a pixel at a cell's top line or left column inside the region with bit=0 SHALL be blue; bit=1 cells are unchanged.
REQ-033 When REG_BANK_DISPLAY_GRID_EN is undefined, no grid logic is compiled, and bit=0 cells are black.

Verification
REQ-034 Defaults: write live[3]=16'h8001, pulse frame_start, then scan y=12..15 -> at x=256..259 and x=316..319 red, all other cells in that row black, and the output 2 clocks after hpos.
REQ-035 Write live[5]=16'hFFFF mid-frame without frame_start -> row 5 stays at its old value until the next frame_start, then green or red as the highlight state dictates.
REQ-036 Drive wr_en=1 (addr 2, data 16'h0004) and frame_start in the same cycle -> the shadow row 2 shows bit 2 set in the following frame, with no one-frame delay.
REQ-037 HOLD_FRAMES=3: write row 1 and count frame_starts -> row 1 is red for 3 frames, then green; a second write at frame 2 restarts the count at 3.
REQ-038 Assert resetn=0 while display_on=1 over lit cells -> the outputs are 0 asynchronously, and after release every cell is black for all rows.
REQ-039 With REG_BANK_DISPLAY_GRID_EN and an all-zero bank -> blue at every x%4==0 or y%4==0 pixel inside the region, and black elsewhere.
